// File: rtl/arb_mux_n.sv
// N-channel registered arbiter/mux: fixed-priority, round-robin or forced-select
// grant feeding a one-deep output register with valid/ready on both sides.
module arb_mux_n #(
  parameter int N_CH   = 8,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  input  logic [N_CH-1:0]          in_valid,
  output logic [N_CH-1:0]          in_ready,
  input  logic [1:0]               mode,
  input  logic [SEL_W-1:0]         force_sel,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam logic [1:0] M_RR    = 2'b01;
  localparam logic [1:0] M_FORCE = 2'b10;

  logic [SEL_W-1:0]  r_last;
  logic [DATA_W-1:0] r_out_data;
  logic [SEL_W-1:0]  r_out_ch;
  logic              r_out_valid;

  logic              w_load_en;
  logic              w_fix_vld, w_rr_vld, w_frc_vld, w_gnt_vld;
  logic [SEL_W-1:0]  w_fix, w_rr, w_frc, w_gnt;
  logic [SEL_W-1:0]  w_start, w_pos;
  logic [SEL_W:0]    w_sum;
  logic [2*N_CH-1:0] w_dbl, w_shift;
  logic [N_CH-1:0]   w_rot;
  logic [DATA_W-1:0] w_gnt_data;

  // rst_n gates the accept so nothing is offered to producers while in reset.
  assign w_load_en = rst_n && (!r_out_valid || out_ready);

  always_comb begin
    w_fix_vld = 1'b0;
    w_fix     = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (in_valid[k]) begin
        w_fix_vld = 1'b1;
        w_fix     = SEL_W'(k);
      end
    end
  end

  // Round-robin: rotate so the channel after r_last sits at bit 0, take the
  // lowest set bit, then rotate the index back with a single wrap correction.
  always_comb begin
    w_start = (r_last == SEL_W'(N_CH - 1)) ? '0 : r_last + 1'b1;
    w_dbl   = {in_valid, in_valid};
    w_shift = w_dbl >> w_start;
    w_rot   = w_shift[N_CH-1:0];
    w_rr_vld = 1'b0;
    w_pos    = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_rr_vld = 1'b1;
        w_pos    = SEL_W'(k);
      end
    end
    w_sum = {1'b0, w_start} + {1'b0, w_pos};
    if (w_sum >= (SEL_W+1)'(N_CH)) w_sum = w_sum - (SEL_W+1)'(N_CH);
    w_rr = w_sum[SEL_W-1:0];
  end

  // An out-of-range force_sel matches no channel and therefore never grants.
  always_comb begin
    w_frc_vld = 1'b0;
    w_frc     = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (force_sel == SEL_W'(k) && in_valid[k]) begin
        w_frc_vld = 1'b1;
        w_frc     = SEL_W'(k);
      end
    end
  end

  always_comb begin
    case (mode)
      M_RR:    begin w_gnt_vld = w_rr_vld;  w_gnt = w_rr;  end
      M_FORCE: begin w_gnt_vld = w_frc_vld; w_gnt = w_frc; end
      default: begin w_gnt_vld = w_fix_vld; w_gnt = w_fix; end
    endcase
  end

  always_comb begin
    w_gnt_data = '0;
    in_ready   = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (w_gnt == SEL_W'(k)) begin
        w_gnt_data  = in_data[k*DATA_W +: DATA_W];
        in_ready[k] = w_gnt_vld && w_load_en;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_last      <= SEL_W'(N_CH - 1);
    end else if (w_load_en) begin
      r_out_valid <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_out_data <= w_gnt_data;
        r_out_ch   <= w_gnt;
        if (mode == M_RR) r_last <= w_gnt;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_arb_mux_n.sv
// Bench for arb_mux_n: directed scenarios plus random traffic against a
// spec-level grant model and an in-order word scoreboard.
module tb_arb_mux_n;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] in_data;
  logic [7:0]  in_valid, in_ready;
  logic [1:0]  mode;
  logic [2:0]  force_sel;
  logic [7:0]  out_data;
  logic [2:0]  out_ch;
  logic        out_valid, out_ready;

  logic [47:0] d6_data;
  logic [5:0]  d6_valid, d6_rdy;
  logic [1:0]  d6_mode;
  logic [2:0]  d6_fs, d6_oc;
  logic [7:0]  d6_od;
  logic        d6_ov, d6_ordy;

  always #5 clk = ~clk;

  arb_mux_n #(.N_CH(8), .DATA_W(8), .SEL_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .force_sel(force_sel),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready));

  arb_mux_n #(.N_CH(6), .DATA_W(8), .SEL_W(3)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_data(d6_data), .in_valid(d6_valid),
    .in_ready(d6_rdy), .mode(d6_mode), .force_sel(d6_fs),
    .out_data(d6_od), .out_ch(d6_oc), .out_valid(d6_ov),
    .out_ready(d6_ordy));

  int          n_tot = 0;
  int          n_bad = 0;
  logic [7:0]  dat [8];
  logic [7:0]  q [$];
  bit          m_ov;
  logic [7:0]  m_od;
  int          m_oc;
  int          m_last;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Grant straight from the arbitration rules; -1 means nobody is granted.
  function automatic int ref_grant(input logic [7:0] v, input logic [1:0] md,
                                   input int fs, input int last);
    if (md == 2'b01) begin
      for (int i = 1; i <= 8; i++) begin
        int c;
        c = (last + i) % 8;
        if (v[c]) return c;
      end
      return -1;
    end
    if (md == 2'b10) return (fs < 8 && v[fs]) ? fs : -1;
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_ov = 1'b0; m_od = 8'h00; m_oc = 0; m_last = 7;
    q.delete();
  endtask

  task automatic tick(input logic [7:0] v, input logic [1:0] md,
                      input logic [2:0] fs, input logic ordy);
    int         g;
    bit         ld;
    logic [7:0] er, w;
    in_valid = v; mode = md; force_sel = fs; out_ready = ordy;
    for (int k = 0; k < 8; k++) in_data[k*8 +: 8] = dat[k];
    #1;
    ld = !m_ov || ordy;
    g  = ref_grant(v, md, int'(fs), m_last);
    er = (ld && g >= 0) ? (8'd1 << g) : 8'd0;
    chk("in_ready", {24'd0, in_ready}, {24'd0, er});
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("sb_underflow", q.size(), 1);
      else begin
        w = q.pop_front();
        chk("sb_data", {24'd0, out_data}, {24'd0, w});
      end
    end
    for (int k = 0; k < 8; k++) if (in_valid[k] && in_ready[k]) q.push_back(dat[k]);
    @(posedge clk);
    if (ld) begin
      m_ov = (g >= 0);
      if (g >= 0) begin
        m_od = dat[g];
        m_oc = g;
        if (md == 2'b01) m_last = g;
      end
    end
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    chk("out_data", {24'd0, out_data}, {24'd0, m_od});
    chk("out_ch", {29'd0, out_ch}, m_oc);
  endtask

  initial begin
    logic [7:0] hold_d;
    logic [2:0] hold_c;
    int         rr_tail [4];
    rr_tail = '{5, 1, 5, 1};

    rst_n = 1'b0;
    for (int k = 0; k < 8; k++) dat[k] = 8'($urandom);
    for (int k = 0; k < 8; k++) in_data[k*8 +: 8] = dat[k];
    in_valid = 8'hFF; mode = 2'b00; force_sel = 3'd0; out_ready = 1'b1;
    d6_data = '0; d6_valid = '0; d6_mode = 2'b00; d6_fs = 3'd0; d6_ordy = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ov", {31'd0, out_valid}, 0);
    chk("rst_od", {24'd0, out_data}, 0);
    chk("rst_oc", {29'd0, out_ch}, 0);
    chk("rst_rdy", {24'd0, in_ready}, 0);
    rst_n = 1'b1;

    dat[0] = 8'hA5;
    tick(8'h01, 2'b00, 3'd0, 1'b1);
    chk("first_od", {24'd0, out_data}, 32'hA5);

    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 8; k++) dat[k] = 8'($urandom);
      tick(8'b1001_0100, 2'b00, 3'd0, 1'b1);
      chk("fix_rdy", {24'd0, in_ready}, 32'h04);
      chk("fix_ch", {29'd0, out_ch}, 2);
    end

    for (int i = 0; i < 12; i++) begin
      tick(8'hFF, 2'b01, 3'd0, 1'b1);
      chk("rr_seq", {29'd0, out_ch}, (i < 9) ? i % 8 : i - 8);
    end
    for (int i = 0; i < 4; i++) begin
      tick(8'h22, 2'b01, 3'd0, 1'b1);
      chk("rr_tail", {29'd0, out_ch}, rr_tail[i]);
    end

    dat[6] = 8'h3C;
    d6_mode = 2'b10; d6_fs = 3'd2; d6_valid = 6'h3F; d6_data = '0;
    d6_data[2*8 +: 8] = 8'h77;
    tick(8'hFF, 2'b10, 3'd6, 1'b1);
    chk("frc_rdy", {24'd0, in_ready}, 32'h40);
    chk("frc_od", {24'd0, out_data}, 32'h3C);
    chk("frc_oc", {29'd0, out_ch}, 6);
    chk("d6_ov", {31'd0, d6_ov}, 1);
    chk("d6_od", {24'd0, d6_od}, 32'h77);
    d6_fs = 3'd7;
    tick(8'hFF, 2'b10, 3'd6, 1'b1);
    chk("d6_oor_rdy", {26'd0, d6_rdy}, 0);
    chk("d6_oor_ov", {31'd0, d6_ov}, 0);
    d6_valid = '0;

    for (int k = 0; k < 8; k++) dat[k] = 8'($urandom);
    tick(8'hFF, 2'b00, 3'd0, 1'b1);
    hold_d = out_data; hold_c = out_ch;
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 8; k++) dat[k] = 8'($urandom);
      tick(8'($urandom) | 8'h01, 2'($urandom), 3'($urandom), 1'b0);
      chk("bp_od", {24'd0, out_data}, {24'd0, hold_d});
      chk("bp_oc", {29'd0, out_ch}, {29'd0, hold_c});
      chk("bp_rdy", {24'd0, in_ready}, 0);
    end
    dat[0] = 8'h5A;
    tick(8'hFF, 2'b00, 3'd0, 1'b1);
    chk("bp_nobubble", {31'd0, out_valid}, 1);
    chk("bp_reload", {24'd0, out_data}, 32'h5A);

    tick(8'hFF, 2'b00, 3'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ov", {31'd0, out_valid}, 0);
    chk("arst_od", {24'd0, out_data}, 0);
    chk("arst_rdy", {24'd0, in_ready}, 0);
    #1 rst_n = 1'b1;
    model_reset();
    tick(8'hFF, 2'b01, 3'd0, 1'b1);
    chk("arst_rr0", {29'd0, out_ch}, 0);
    tick(8'hFF, 2'b01, 3'd0, 1'b1);
    chk("arst_rr1", {29'd0, out_ch}, 1);

    repeat (1000) begin
      for (int k = 0; k < 8; k++) dat[k] = 8'($urandom);
      tick(8'($urandom), 2'($urandom), 3'($urandom), ($urandom_range(0, 3) != 0));
    end
    chk("sb_left", q.size(), out_valid ? 1 : 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
